// File: rtl/kmeans_centroid_update_k3n2_pkg.sv
// Shared constants and FSM encoding for the k-means (k=3, n=2) datapath.
package kmeans_pkg;

  localparam int KMEANS_K = 3;
  localparam int KMEANS_N = 2;
  localparam int CIDX_W   = 2;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    READ  = 5'b00010,
    DIV   = 5'b00100,
    STORE = 5'b01000,
    DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/kmeans_centroid_update_k3n2_if.sv
// Read port between the centroid update stage and the accumulator block.
interface kmeans_acc_rd_if #(
  parameter int acc_width = 16,
  parameter int qty_width = 8
);
  import kmeans_pkg::*;

  logic                 rd_acc_en;
  logic [CIDX_W-1:0]    rd_acc_centroid;
  logic [acc_width-1:0] acc0_in;
  logic [acc_width-1:0] acc1_in;
  logic [qty_width-1:0] count_in;

  modport master (
    output rd_acc_en, rd_acc_centroid,
    input  acc0_in, acc1_in, count_in
  );

  modport slave (
    input  rd_acc_en, rd_acc_centroid,
    output acc0_in, acc1_in, count_in
  );

endinterface

// File: rtl/kmeans_centroid_update_k3n2_divider.sv
// Restoring sequential divider: one quotient bit per cycle, MSB first, remainder dropped.
module kmeans_seq_divider #(
  parameter int dividend_width = 16,
  parameter int divisor_width  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic [dividend_width-1:0] quotient,
  output logic                      valid
);

  localparam int CW = $clog2(dividend_width);

  logic [divisor_width-1:0] rem;
  logic [divisor_width-1:0] dvs;
  logic [CW-1:0]            cnt;
  logic                     running;
  logic [divisor_width:0]   trial;
  logic [divisor_width:0]   diff;
  logic                     take;

  // The quotient register doubles as the dividend shifter: bits leave at the top as quotient bits enter at the bottom.
  always_comb begin
    trial = {rem, quotient[dividend_width-1]};
    take  = (trial >= {1'b0, dvs});
    diff  = trial - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      valid    <= 1'b0;
    end else if (start) begin
      quotient <= dividend;
      rem      <= '0;
      dvs      <= divisor;
      cnt      <= '0;
      running  <= 1'b1;
      valid    <= 1'b0;
    end else if (running) begin
      quotient <= {quotient[dividend_width-2:0], take};
      rem      <= take ? diff[divisor_width-1:0] : trial[divisor_width-1:0];
      cnt      <= cnt + 1'b1;
      if (cnt == CW'(dividend_width - 1)) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/kmeans_centroid_update_k3n2.sv
// Centroid update: reads each centroid's accumulators, divides by its count and
// registers the new centroid, then flags convergence and clears the accumulators.
module kmeans_centroid_update_k3n2
  import kmeans_pkg::*;
#(
  parameter int input_data_width         = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int acc_width                = 16,
  parameter logic [input_data_width-1:0] k0_d0_initial = input_data_width'(0),
  parameter logic [input_data_width-1:0] k0_d1_initial = input_data_width'(0),
  parameter logic [input_data_width-1:0] k1_d0_initial = input_data_width'(1),
  parameter logic [input_data_width-1:0] k1_d1_initial = input_data_width'(1),
  parameter logic [input_data_width-1:0] k2_d0_initial = input_data_width'(2),
  parameter logic [input_data_width-1:0] k2_d1_initial = input_data_width'(2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [input_data_width-1:0] k0d0,
  input  logic [input_data_width-1:0] k0d1,
  input  logic [input_data_width-1:0] k1d0,
  input  logic [input_data_width-1:0] k1d1,
  input  logic [input_data_width-1:0] k2d0,
  input  logic [input_data_width-1:0] k2d1,
  kmeans_acc_rd_if.master             acc_rd,
  output logic [input_data_width-1:0] new_k0d0,
  output logic [input_data_width-1:0] new_k0d1,
  output logic [input_data_width-1:0] new_k1d0,
  output logic [input_data_width-1:0] new_k1d1,
  output logic [input_data_width-1:0] new_k2d0,
  output logic [input_data_width-1:0] new_k2d1,
  output logic                        busy,
  output logic                        done,
  output logic                        converged,
  output logic                        acc_clear
);

  localparam int W  = input_data_width;
  localparam int CW = $clog2(acc_width);

  state_t                              state, next_state;
  logic [CIDX_W-1:0]                   k;
  logic [CW-1:0]                       div_cnt;
  logic [input_data_qty_bit_width-1:0] count_lat;
  logic                                conv_acc;
  logic [W-1:0]                        cent_q   [KMEANS_K][KMEANS_N];
  logic [W-1:0]                        old_cent [KMEANS_K][KMEANS_N];
  logic [acc_width-1:0]                quo      [KMEANS_N];
  logic [KMEANS_N-1:0]                 div_valid;
  logic [W-1:0]                        result   [KMEANS_N];
  logic [KMEANS_N-1:0]                 match;
  logic                                div_start;

  assign old_cent[0][0] = k0d0;
  assign old_cent[0][1] = k0d1;
  assign old_cent[1][0] = k1d0;
  assign old_cent[1][1] = k1d1;
  assign old_cent[2][0] = k2d0;
  assign old_cent[2][1] = k2d1;

  assign new_k0d0 = cent_q[0][0];
  assign new_k0d1 = cent_q[0][1];
  assign new_k1d0 = cent_q[1][0];
  assign new_k1d1 = cent_q[1][1];
  assign new_k2d0 = cent_q[2][0];
  assign new_k2d1 = cent_q[2][1];

  kmeans_seq_divider #(
    .dividend_width (acc_width),
    .divisor_width  (input_data_qty_bit_width)
  ) u_div_d0 (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_rd.acc0_in),
    .divisor  (acc_rd.count_in),
    .quotient (quo[0]),
    .valid    (div_valid[0])
  );

  kmeans_seq_divider #(
    .dividend_width (acc_width),
    .divisor_width  (input_data_qty_bit_width)
  ) u_div_d1 (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_rd.acc1_in),
    .divisor  (acc_rd.count_in),
    .quotient (quo[1]),
    .valid    (div_valid[1])
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state             = state;
    busy                   = (state != IDLE);
    done                   = 1'b0;
    acc_clear              = 1'b0;
    div_start              = 1'b0;
    acc_rd.rd_acc_en       = 1'b0;
    acc_rd.rd_acc_centroid = k;
    case (state)
      IDLE:  if (start) next_state = READ;
      READ: begin
        acc_rd.rd_acc_en = 1'b1;
        div_start        = 1'b1;
        next_state       = DIV;
      end
      DIV:   if (div_cnt == CW'(acc_width - 1)) next_state = STORE;
      STORE: next_state = (k == CIDX_W'(KMEANS_K - 1)) ? DONE : READ;
      DONE: begin
        done       = 1'b1;
        acc_clear  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // An empty cluster keeps its old coordinate; oversized quotients clamp to all-ones.
  always_comb begin
    for (int d = 0; d < KMEANS_N; d++) begin
      if (!div_valid[d] || count_lat == '0)
        result[d] = old_cent[k][d];
      else if (|quo[d][acc_width-1:W])
        result[d] = '1;
      else
        result[d] = quo[d][W-1:0];
      match[d] = (result[d] == old_cent[k][d]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      div_cnt      <= '0;
      count_lat    <= '0;
      conv_acc     <= 1'b0;
      converged    <= 1'b0;
      cent_q[0][0] <= k0_d0_initial;
      cent_q[0][1] <= k0_d1_initial;
      cent_q[1][0] <= k1_d0_initial;
      cent_q[1][1] <= k1_d1_initial;
      cent_q[2][0] <= k2_d0_initial;
      cent_q[2][1] <= k2_d1_initial;
    end else begin
      case (state)
        IDLE: if (start) begin
          k        <= '0;
          conv_acc <= 1'b1;
        end
        READ: begin
          count_lat <= acc_rd.count_in;
          div_cnt   <= '0;
        end
        DIV: div_cnt <= div_cnt + 1'b1;
        STORE: begin
          for (int d = 0; d < KMEANS_N; d++) cent_q[k][d] <= result[d];
          conv_acc <= conv_acc & (&match);
          if (k != CIDX_W'(KMEANS_K - 1)) k <= k + 1'b1;
        end
        DONE: converged <= conv_acc;
        default: ;
      endcase
    end
  end

endmodule
